uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: accepts bytes from fabric logic into an internal FIFO and serialises them onto `tx_out` as 8-bit frames with optional even/odd parity and one stop bit, at a selectable baud rate derived from the 50 MHz board clock. It is the transmit-side counterpart of the existing receive path and shares its baud-select and parity-control conventions, so both directions of a link can be driven from the same switches.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `FIFO_DEPTH`, 16, byte entries in the transmit FIFO (power of two, ≥2)
- `clk`  input  1  system clock, 50 MHz
- `reset_n`  input  1  reset; one clock, asynchronous, active-low
- `baud_select`  input  2  00: 9600, 01: 19200, 10: 57600, 11: 115200
- `parity_enable`  input  1  1: insert parity bit
- `parity_odd_even`  input  1  0: even, 1: odd
- `tx_write`  input  1  push `tx_data` this cycle (one byte per cycle high)
- `tx_data`  input  8  byte to push
- `tx_out`  output  1  serial line, idle high
- `fifo_empty`  output  1  FIFO holds 0 entries
- `fifo_full`  output  1  FIFO holds `FIFO_DEPTH` entries
- `tx_busy`  output  1  state ≠ IDLE
- `overflow`  output  1  sticky: a write was dropped while full
- `current_state`  output  3  FSM state encoding

## Operation
- States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Other encodings are unreachable and return to IDLE.
- IDLE and !fifo_empty: at the edge, pop the head into the shift register, latch `baud_select`, `parity_enable` and `parity_odd_even`, and go to START.
- START drives 0. DATA drives bits 0..7, LSB first. PARITY drives the parity bit. STOP drives 1.
- Each bit lasts exactly DIV clk cycles.
- DIV = CLK_FREQ/baud, truncated: 5208, 2604, 868, 434.
- Transitions:
  - START→DATA.
  - DATA after bit 7 → PARITY if the latched parity_enable is set, else STOP.
  - PARITY→STOP.
  - STOP→IDLE.
- Parity bit = ^data XOR parity_odd_even (the latched value).
- Changing the control inputs mid-frame has no effect until the next frame.
- FIFO write: tx_write && !fifo_full stores tx_data. tx_write && fifo_full drops the byte and sets `overflow`, which stays set until reset.
- Full/empty are evaluated before a same-cycle pop. A write at full is dropped even if a pop occurs in the same cycle.
- Write and pop in the same cycle with count ≥1: both occur and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: tx_out=1, current_state=0, tx_busy=0, fifo_empty=1, fifo_full=0, overflow=0. Pointers, count and baud counter are 0.
- Reset asserted mid-frame forces tx_out=1 immediately (asynchronous) and discards FIFO contents.
- All outputs are registered.
- A write into an empty FIFO in IDLE: fifo_empty falls one cycle after the write edge, and tx_out falls one cycle after that. First-bit latency is 2 clk.
- Frame length: 10×DIV cycles, or 11×DIV with parity, followed by exactly one IDLE cycle before the next START when the FIFO is non-empty.
- The baud counter restarts at 0 on every state change. There is no fractional accumulation.

## Structure
- Package `uart_pkg` holds:
  - state localparams (IDLE..STOP) and the 3-bit state type
  - baud divisor constants as a function of CLK_FREQ and baud_select
  - a parity function (data, odd) → bit, for reuse by the receiver
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH): write/read strobes, data in/out, empty, full.
- The FSM, shift register, bit counter and baud counter live in the top block.

## Test plan
- Reset, baud 11, parity off: write 0x55 once. Then tx_out=0 for 434 cycles, bits 1,0,1,0,1,0,1,0 at 434 cycles each, then 1. tx_busy is high for 4340 cycles.
- Parity on, even, 0x41 → parity bit 0. Odd, 0x41 → parity bit 1. Frame is 11×434 cycles.
- Write 3 bytes in consecutive cycles: frames appear in order, each separated by exactly 1 idle-high cycle, and fifo_empty rises on the third pop.
- Write 17 bytes at DEPTH=16: fifo_full after 16, the 17th dropped, overflow=1. The first byte is popped after the FIFO has filled, so exactly 16 frames are emitted.
- Toggle baud_select 11→00 during DATA: the current frame finishes at 434 cycles/bit, and the next frame runs at 5208 cycles/bit.
- Assert reset_n low at mid-data bit: tx_out=1 at once, then state=0, empty=1, overflow=0, and no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, baud divisors and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    // Cycles per bit; truncated, the receiver uses the same table.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [1:0] sel);
        case (sel)
            2'b00:   return clk_freq / BAUD_9600;
            2'b01:   return clk_freq / BAUD_19200;
            2'b10:   return clk_freq / BAUD_57600;
            default: return clk_freq / BAUD_115200;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered empty/full flags
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             do_wr, do_rd;

    // Flags are taken from the registered state, so a write at full is refused
    // even when a pop frees a slot on the same edge.
    always_comb begin
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        empty_d  = (count_d == '0);
        full_d   = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8 data bits, optional parity, one stop
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] baud_select,
    input  logic       parity_enable,
    input  logic       parity_odd_even,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       tx_busy,
    output logic       overflow,
    output logic [2:0] current_state
);
    localparam int CNT_W = $clog2(baud_div(CLK_FREQ, 2'b00) + 1);

    uart_state_e      state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d, div_m1;
    logic [1:0]       baud_sel_q, baud_sel_d;
    logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic             tx_out_q, tx_out_d, busy_q, busy_d, overflow_q, overflow_d;
    logic             pop, bit_end;
    logic [7:0]       fifo_rd_data;
    logic             fifo_empty_w, fifo_full_w;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (tx_write),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty_w),
        .full    (fifo_full_w)
    );

    // Divisor follows the select latched at frame start, never the live input.
    assign div_m1  = CNT_W'(baud_div(CLK_FREQ, baud_sel_q) - 32'd1);
    assign bit_end = (baud_cnt_q == div_m1);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
        baud_sel_d = baud_sel_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (tx_write & fifo_full_w);

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty_w) begin
                    pop        = 1'b1;
                    shift_d    = fifo_rd_data;
                    bit_cnt_d  = '0;
                    baud_sel_d = baud_select;
                    par_en_d   = parity_enable;
                    par_bit_d  = parity_bit(fifo_rd_data, parity_odd_even);
                    state_d    = START;
                end
            end
            START: if (bit_end) begin
                baud_cnt_d = '0;
                state_d    = DATA;
            end
            DATA: if (bit_end) begin
                baud_cnt_d = '0;
                shift_d    = {1'b0, shift_q[7:1]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
                baud_cnt_d = '0;
                state_d    = STOP;
            end
            STOP: if (bit_end) begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase

        // Line level is registered from the next state so it moves with the FSM.
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = par_bit_d;
            default: tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            baud_sel_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            baud_sel_q <= baud_sel_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_out        = tx_out_q;
    assign tx_busy       = busy_q;
    assign overflow      = overflow_q;
    assign fifo_empty    = fifo_empty_w;
    assign fifo_full     = fifo_full_w;
    assign current_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for the buffered UART transmitter
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 5_000_000;
    localparam int DEPTH    = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] baud_select;
    logic       parity_enable, parity_odd_even, tx_write;
    logic [7:0] tx_data;
    logic       tx_out, fifo_empty, fifo_full, tx_busy, overflow;
    logic [2:0] current_state;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .baud_select     (baud_select),
        .parity_enable   (parity_enable),
        .parity_odd_even (parity_odd_even),
        .tx_write        (tx_write),
        .tx_data         (tx_data),
        .tx_out          (tx_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .tx_busy         (tx_busy),
        .overflow        (overflow),
        .current_state   (current_state)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
        int         div;
    } frame_t;

    frame_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    int          frames_seen = 0;
    bit          abort_req = 1'b0;
    logic        last_par = 1'bx;
    int unsigned div50 [4] = '{5208, 2604, 868, 434};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tb_div(input logic [1:0] sel);
        case (sel)
            2'b00:   return CLK_FREQ / 9600;
            2'b01:   return CLK_FREQ / 19200;
            2'b10:   return CLK_FREQ / 57600;
            default: return CLK_FREQ / 115200;
        endcase
    endfunction

    task automatic exp_push(input logic [7:0] d, input logic [1:0] sel, input bit pe, input bit odd);
        frame_t f;
        f.data    = d;
        f.par_en  = pe;
        f.par_bit = (^d) ^ odd;
        f.div     = tb_div(sel);
        sb.push_back(f);
    endtask

    // Call at #1 after a posedge; returns at #1 after the next posedge.
    task automatic drive_byte(input logic [7:0] d);
        tx_write = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        tx_write = 1'b0;
    endtask

    task automatic time_busy(input string tag, input int exp_len);
        int n = 0;
        int g = 0;
        while (!tx_busy && g < 1000) begin @(negedge clk); g++; end
        while (tx_busy && n < 100000) begin n++; @(negedge clk); end
        check_eq(tag, n, exp_len);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        do begin @(negedge clk); g++; end
        while ((tx_busy || !fifo_empty || sb.size() != 0) && g < 30000);
        repeat (2) @(negedge clk);
        check_eq(tag, {tx_busy, fifo_empty, sb.size() == 0}, 3'b011);
    endtask

    task automatic wait_state(input logic [2:0] st);
        int g = 0;
        while (current_state != st && g < 20000) begin @(negedge clk); g++; end
        check_eq("reach_state", current_state, st);
    endtask

    // Frame monitor: checks every cycle of each frame against the scoreboard head.
    initial begin : monitor
        frame_t      f;
        logic [10:0] bits;
        int          nb, errs, g;
        bit          aborted, pend, gap_hi;
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (abort_req) begin
                abort_req = 1'b0;
            end else if (reset_n === 1'b1 && tx_out === 1'b0) begin
                check_eq("frame_expected", sb.size() > 0, 1);
                if (sb.size() == 0) begin
                    g = 0;
                    while (tx_out === 1'b0 && g < 20000) begin @(negedge clk); g++; end
                end else begin
                    f       = sb.pop_front();
                    bits    = {1'b1, (f.par_en ? f.par_bit : 1'b1), f.data, 1'b0};
                    nb      = f.par_en ? 11 : 10;
                    errs    = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < nb && !aborted; b++) begin
                        for (int c = 0; c < f.div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (abort_req) begin
                                aborted   = 1'b1;
                                abort_req = 1'b0;
                            end else begin
                                if (tx_out !== bits[b]) errs++;
                                if (f.par_en && b == 9 && c == f.div / 2) last_par = tx_out;
                            end
                        end
                    end
                    if (!aborted) begin
                        check_eq("frame_wave", errs, 0);
                        frames_seen++;
                        if (sb.size() > 0) begin
                            @(negedge clk); gap_hi = tx_out;
                            @(negedge clk);
                            check_eq("idle_gap", {gap_hi, tx_out}, 2'b10);
                            pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(60000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fr0, low;
        reset_n = 1'b0; baud_select = 2'b11; parity_enable = 1'b0; parity_odd_even = 1'b0;
        tx_write = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_out", tx_out, 1);
        check_eq("rst_state", current_state, 0);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_empty", fifo_empty, 1);
        check_eq("rst_full", fifo_full, 0);
        check_eq("rst_overflow", overflow, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        for (int i = 0; i < 4; i++) check_eq("div_50m", uart_pkg::baud_div(50_000_000, 2'(i)), div50[i]);

        // 0x55, no parity: latency and frame length
        @(posedge clk); #1;
        exp_push(8'h55, 2'b11, 1'b0, 1'b0);
        drive_byte(8'h55);
        @(negedge clk);
        check_eq("empty_after_write", fifo_empty, 0);
        check_eq("tx_idle_after_write", tx_out, 1);
        @(negedge clk);
        check_eq("start_tx_out", tx_out, 0);
        check_eq("start_state", current_state, 1);
        check_eq("start_busy", tx_busy, 1);
        check_eq("empty_after_pop", fifo_empty, 1);
        time_busy("busy_len_8n1", 10 * tb_div(2'b11));
        wait_idle("idle_8n1");

        // parity even then odd on 0x41
        parity_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            parity_odd_even = k[0];
            @(posedge clk); #1;
            exp_push(8'h41, 2'b11, 1'b1, k[0]);
            drive_byte(8'h41);
            time_busy("busy_len_par", 11 * tb_div(2'b11));
            wait_idle("idle_par");
            check_eq("parity_bit_0x41", last_par, k[0]);
        end
        parity_enable = 1'b0; parity_odd_even = 1'b0;

        // three back-to-back writes
        @(posedge clk); #1;
        exp_push(8'hA3, 2'b11, 1'b0, 1'b0); drive_byte(8'hA3);
        exp_push(8'h0F, 2'b11, 1'b0, 1'b0); drive_byte(8'h0F);
        exp_push(8'hC8, 2'b11, 1'b0, 1'b0); drive_byte(8'hC8);
        for (int k = 0; k < 3; k++) begin
            int g = 0;
            while (!tx_busy && g < 5000) begin @(negedge clk); g++; end
            check_eq("empty_at_pop", fifo_empty, k == 2);
            g = 0;
            while (tx_busy && g < 5000) begin @(negedge clk); g++; end
        end
        wait_idle("idle_three");

        // overflow: lead frame in flight, then 17 writes into an empty FIFO
        fr0 = frames_seen;
        @(posedge clk); #1;
        exp_push(8'hE7, 2'b11, 1'b0, 1'b0); drive_byte(8'hE7);
        begin
            int g = 0;
            while (!tx_busy && g < 100) begin @(negedge clk); g++; end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            tx_write = 1'b1;
            tx_data  = 8'h10 + 8'(i);
            if (i < 16) exp_push(tx_data, 2'b11, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (i == 14) check_eq("full_at_15", fifo_full, 0);
            if (i == 15) begin
                check_eq("full_at_16", fifo_full, 1);
                check_eq("overflow_before_drop", overflow, 0);
            end
            if (i == 16) begin
                check_eq("full_after_drop", fifo_full, 1);
                check_eq("overflow_after_drop", overflow, 1);
            end
        end
        tx_write = 1'b0;
        wait_idle("idle_overflow");
        check_eq("overflow_frames", frames_seen - fr0, 17);
        check_eq("overflow_sticky", overflow, 1);

        // baud change mid-frame applies only to the next frame
        fr0 = frames_seen;
        @(posedge clk); #1;
        exp_push(8'h3C, 2'b11, 1'b0, 1'b0); drive_byte(8'h3C);
        exp_push(8'hA5, 2'b00, 1'b0, 1'b0); drive_byte(8'hA5);
        wait_state(3'd2);
        repeat (10) @(negedge clk);
        baud_select = 2'b00;
        wait_idle("idle_toggle");
        check_eq("toggle_frames", frames_seen - fr0, 2);
        baud_select = 2'b11;

        // asynchronous reset in the middle of a data bit
        @(posedge clk); #1;
        exp_push(8'h96, 2'b11, 1'b0, 1'b0); drive_byte(8'h96);
        exp_push(8'h69, 2'b11, 1'b0, 1'b0); drive_byte(8'h69);
        exp_push(8'hFF, 2'b11, 1'b0, 1'b0); drive_byte(8'hFF);
        wait_state(3'd2);
        repeat (3 * tb_div(2'b11) + tb_div(2'b11) / 2) @(negedge clk);
        check_eq("pre_reset_overflow", overflow, 1);
        #2;
        abort_req = 1'b1;
        reset_n   = 1'b0;
        #1;
        check_eq("reset_tx_out_now", tx_out, 1);
        check_eq("reset_state", current_state, 0);
        check_eq("reset_empty", fifo_empty, 1);
        check_eq("reset_overflow", overflow, 0);
        check_eq("reset_busy", tx_busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        fr0 = frames_seen;
        low = 0;
        repeat (3 * 10 * tb_div(2'b11)) begin
            @(negedge clk);
            if (tx_out !== 1'b1) low++;
        end
        check_eq("no_tx_after_reset", low, 0);
        check_eq("no_frames_after_reset", frames_seen - fr0, 0);
        check_eq("post_reset_state", current_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
